// File: rtl/sccb_cfg_master.sv
// Camera configuration engine: walks a synchronous register ROM and issues one
// 3-phase SCCB write (ID, sub-address, data) per entry on an open-drain SIOC/SIOD pair.
module sccb_cfg_master #(
  parameter int         CLK_F    = 25_000_000,
  parameter int         SCCB_F   = 100_000,
  parameter logic [7:0] SLAVE_ID = 8'h42,
  parameter int         DELAY_MS = 10
) (
  input  logic        i_sysclk,
  input  logic        i_rstn,
  input  logic        i_cfg_start,
  output logic [7:0]  o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic        o_sioc,
  output logic        o_siod_oe,
  output logic        o_cfg_busy,
  output logic        o_cfg_done
);

  localparam int Q    = CLK_F / (4 * SCCB_F);
  localparam int DLY  = (CLK_F / 1000) * DELAY_MS;
  localparam int CMAX = (4 * Q > DLY) ? 4 * Q : DLY;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] Q1_C     = CW'(Q);
  localparam logic [CW-1:0] Q2_C     = CW'(2 * Q);
  localparam logic [CW-1:0] Q3_C     = CW'(3 * Q);
  localparam logic [CW-1:0] Q2M_C    = CW'(2 * Q - 1);
  localparam logic [CW-1:0] Q4M_C    = CW'(4 * Q - 1);
  localparam logic [CW-1:0] DLYM_C   = CW'(DLY - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_START  = 4'd3,
    S_BITS   = 4'd4,
    S_STOP   = 4'd5,
    S_GAP    = 4'd6,
    S_DELAY  = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [4:0]    bit_r, bit_s;
  logic [26:0]   shift_r, shift_s;
  logic [7:0]    addr_r, addr_s;
  logic          sioc_r, sioc_s;
  logic          oe_r, oe_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;

  // State, counters and all output registers; outputs reflect the state being entered.
  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      state_r <= S_IDLE;
      cnt_r   <= CNT_ZERO;
      bit_r   <= 5'd0;
      shift_r <= 27'd0;
      addr_r  <= 8'd0;
      sioc_r  <= 1'b1;
      oe_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      addr_r  <= addr_s;
      sioc_r  <= sioc_s;
      oe_r    <= oe_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state sequencing followed by the bus pin decode of the upcoming position.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    addr_s  = addr_r;
    busy_s  = busy_r;
    done_s  = done_r;
    sioc_s  = 1'b1;
    oe_s    = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (i_cfg_start) begin
          state_s = S_FETCH;
          addr_s  = 8'd0;
          busy_s  = 1'b1;
          done_s  = 1'b0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: state_s = S_DECODE;
      S_DECODE: begin
        cnt_s = CNT_ZERO;
        bit_s = 5'd0;
        if (i_rom_data == 16'hFFFF) begin
          state_s = S_DONE;
        end else if (i_rom_data == 16'hFFF0) begin
          state_s = S_DELAY;
        end else begin
          // ACK slots are loaded as 1 so they go out released
          shift_s = {SLAVE_ID, 1'b1, i_rom_data[15:8], 1'b1, i_rom_data[7:0], 1'b1};
          state_s = S_START;
        end
      end
      S_START: begin
        if (cnt_r == Q2M_C) begin
          cnt_s   = CNT_ZERO;
          state_s = S_BITS;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_BITS: begin
        if (cnt_r == Q4M_C) begin
          cnt_s   = CNT_ZERO;
          shift_s = {shift_r[25:0], 1'b1};
          if (bit_r == 5'd26) begin
            bit_s   = 5'd0;
            state_s = S_STOP;
          end else begin
            bit_s = bit_r + 5'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_STOP: begin
        if (cnt_r == Q4M_C) begin
          cnt_s   = CNT_ZERO;
          state_s = S_GAP;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_GAP, S_DELAY: begin
        if (cnt_r == ((state_r == S_GAP) ? Q4M_C : DLYM_C)) begin
          cnt_s = CNT_ZERO;
          // the last ROM slot ends the sequence instead of wrapping to 0
          if (addr_r == 8'd255) begin
            state_s = S_DONE;
          end else begin
            addr_s  = addr_r + 8'd1;
            state_s = S_FETCH;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_DONE: begin
        busy_s  = 1'b0;
        done_s  = 1'b1;
        state_s = S_IDLE;
      end
      default: state_s = S_IDLE;
    endcase

    case (state_s)
      S_START: begin
        sioc_s = 1'b1;
        oe_s   = 1'b1;
      end
      S_BITS: begin
        // SIOD moves only Q cycles into the low half, never while SIOC is high
        sioc_s = (cnt_s >= Q2_C);
        oe_s   = (cnt_s < Q1_C) ? oe_r : ~shift_s[26];
      end
      S_STOP: begin
        sioc_s = (cnt_s >= Q2_C);
        oe_s   = (cnt_s < Q3_C);
      end
      default: begin
        sioc_s = 1'b1;
        oe_s   = 1'b0;
      end
    endcase
  end

  assign o_rom_addr = addr_r;
  assign o_sioc     = sioc_r;
  assign o_siod_oe  = oe_r;
  assign o_cfg_busy = busy_r;
  assign o_cfg_done = done_r;

endmodule
